// File: rtl/ex_pipe_pkg.sv
// Shared defines for the execute stage: operation/class encodings, default
// data width and the zero word, plus the op-to-class lookup used to reject
// mismatched aluop/alusel pairs.
// Optional multiplier support is selected by the EX_PIPE_MUL_EN macro.
package ex_pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ALUOP_W  = 8;
    localparam int unsigned ALUSEL_W = 3;

    localparam logic [XLEN_DEF-1:0] ZeroWord = '0;

    // Operation codes
    localparam logic [ALUOP_W-1:0] OP_NOP  = 8'h00;
    localparam logic [ALUOP_W-1:0] OP_OR   = 8'h25;
    localparam logic [ALUOP_W-1:0] OP_AND  = 8'h24;
    localparam logic [ALUOP_W-1:0] OP_XOR  = 8'h26;
    localparam logic [ALUOP_W-1:0] OP_SLL  = 8'h7C;
    localparam logic [ALUOP_W-1:0] OP_SRL  = 8'h02;
    localparam logic [ALUOP_W-1:0] OP_SRA  = 8'h03;
    localparam logic [ALUOP_W-1:0] OP_ADD  = 8'h20;
    localparam logic [ALUOP_W-1:0] OP_SUB  = 8'h22;
    localparam logic [ALUOP_W-1:0] OP_SLT  = 8'h2A;
    localparam logic [ALUOP_W-1:0] OP_SLTU = 8'h2B;
    localparam logic [ALUOP_W-1:0] OP_MUL  = 8'h18;

    // Result classes
    localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'd0;
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'd1;
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'd2;
    localparam logic [ALUSEL_W-1:0] SEL_ARITH = 3'd4;
    localparam logic [ALUSEL_W-1:0] SEL_MUL   = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } ex_state_e;

    // Class an operation belongs to; unknown operations map to SEL_NOP
    function automatic logic [ALUSEL_W-1:0] sel_of(input logic [ALUOP_W-1:0] op);
        logic [ALUSEL_W-1:0] sel;
        sel = SEL_NOP;
        case (op)
            OP_OR, OP_AND, OP_XOR:             sel = SEL_LOGIC;
            OP_SLL, OP_SRL, OP_SRA:            sel = SEL_SHIFT;
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU:   sel = SEL_ARITH;
            OP_MUL:                            sel = SEL_MUL;
            default:                           sel = SEL_NOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// One partial-product step per cycle after start; done pulses on the cycle
// whose edge completes the XLEN-th step, with product valid alongside it.
// Ports: clk, rst (sync, active-high), start (load operands), abort (drop
// the operation), a/b operands, done (combinational), product (combinational).
module ex_mul_iter
    import ex_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplr;
    logic [XLEN-1:0]  acc_next;

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    assign acc_next = acc + (mplr[0] ? mcand : '0);
    assign done     = run && (cnt == CNT_W'(XLEN - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            run   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            acc   <= '0;
            mcand <= a;
            mplr  <= b;
        end else if (run) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// Execute stage: single-cycle logic/shift/arithmetic ops with a registered,
// back-pressured result, and (with EX_PIPE_MUL_EN defined) an iterative
// multi-cycle MUL. Without the macro, MUL is treated as an unknown op.
// Ports: clk, rst (sync, active-high); valid_i/ready_o upstream handshake;
// aluop_i, alusel_i, reg1_i, reg2_i, rd_i, wreg_i instruction fields;
// flush_i discards in-flight work; valid_o/ready_i downstream handshake;
// rd_o, wreg_o, wdata_o registered result; busy_o multiply in progress.
module ex_pipe
    import ex_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [XLEN-1:0]     reg1_i,
    input  logic [XLEN-1:0]     reg2_i,
    input  logic [RADDR_W-1:0]  rd_i,
    input  logic                wreg_i,
    input  logic                flush_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [RADDR_W-1:0]  rd_o,
    output logic                wreg_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic                busy_o
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic               idle;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               valid_d;
    logic               wreg_d;
    logic [RADDR_W-1:0] rd_d;
    logic [XLEN-1:0]    wdata_d;

`ifdef EX_PIPE_MUL_EN
    ex_state_e       state_q;
    ex_state_e       state_d;
    logic            is_mul;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign idle   = (state_q == S_IDLE);
    assign busy_o = (state_q == S_MUL);
    assign is_mul = (aluop_i == OP_MUL) && (alusel_i == SEL_MUL);

    ex_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .abort  (flush_i),
        .a      (reg1_i),
        .b      (reg2_i),
        .done   (mul_done),
        .product(mul_product)
    );
`else
    assign idle   = 1'b1;
    assign busy_o = 1'b0;
`endif

    // Flush blocks acceptance; a held result blocks it until drained
    assign ready_o = idle && !flush_i && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o;
    assign shamt   = reg2_i[SHAMT_W-1:0];

    // Single-cycle result; zero for unknown ops or op/class mismatch
    always_comb begin
        alu_res = '0;
        if (sel_of(aluop_i) == alusel_i) begin
            case (aluop_i)
                OP_OR:   alu_res = reg1_i | reg2_i;
                OP_AND:  alu_res = reg1_i & reg2_i;
                OP_XOR:  alu_res = reg1_i ^ reg2_i;
                OP_SLL:  alu_res = reg1_i << shamt;
                OP_SRL:  alu_res = reg1_i >> shamt;
                OP_SRA:  alu_res = $signed(reg1_i) >>> shamt;
                OP_ADD:  alu_res = reg1_i + reg2_i;
                OP_SUB:  alu_res = reg1_i - reg2_i;
                OP_SLT:  alu_res = XLEN'($signed(reg1_i) < $signed(reg2_i));
                OP_SLTU: alu_res = XLEN'(reg1_i < reg2_i);
                default: alu_res = '0;
            endcase
        end
    end

    // Next state and next output register values
    always_comb begin
        valid_d = valid_o;
        rd_d    = rd_o;
        wreg_d  = wreg_o;
        wdata_d = wdata_o;
`ifdef EX_PIPE_MUL_EN
        state_d   = state_q;
        mul_start = 1'b0;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
`ifdef EX_PIPE_MUL_EN
            state_d = S_IDLE;
`endif
        end else begin
            if (valid_o && ready_i) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                rd_d   = rd_i;
                wreg_d = wreg_i && (rd_i != '0);
`ifdef EX_PIPE_MUL_EN
                // MUL keeps valid_o low until the multiplier finishes
                if (is_mul) begin
                    mul_start = 1'b1;
                    state_d   = S_MUL;
                end else begin
                    valid_d = 1'b1;
                    wdata_d = alu_res;
                end
`else
                valid_d = 1'b1;
                wdata_d = alu_res;
`endif
            end
`ifdef EX_PIPE_MUL_EN
            if ((state_q == S_MUL) && mul_done) begin
                valid_d = 1'b1;
                wdata_d = mul_product;
                state_d = S_IDLE;
            end
`endif
        end
    end

`ifdef EX_PIPE_MUL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            rd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
        end else begin
            valid_o <= valid_d;
            rd_o    <= rd_d;
            wreg_o  <= wreg_d;
            wdata_o <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ex_pipe.sv
// Self-checking bench for ex_pipe: directed vector table, back-pressure and
// reset/flush sequences, multi-cycle MUL (when EX_PIPE_MUL_EN is defined),
// and random single-cycle traffic against a transaction-level reference.
module tb_ex_pipe;
    import ex_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  rd_i;
    logic        wreg_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  rd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_pipe #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .rd_i(rd_i), .wreg_i(wreg_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .rd_o(rd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] exp_data;
        logic        exp_wreg;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic wreg);
        valid_i  = 1'b1;
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        rd_i     = rd;
        wreg_i   = wreg;
    endtask

    function automatic logic [2:0] class_of(input logic [7:0] op);
        if (op == OP_OR || op == OP_AND || op == OP_XOR) return SEL_LOGIC;
        if (op == OP_SLL || op == OP_SRL || op == OP_SRA) return SEL_SHIFT;
        if (op == OP_ADD || op == OP_SUB || op == OP_SLT || op == OP_SLTU) return SEL_ARITH;
        if (op == OP_MUL) return SEL_MUL;
        return 3'd7;
    endfunction

    // Reference result from plain integer arithmetic
    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int              sa32 = int'(a);
        int              sb32 = int'(b);
        longint          sa = 64'(sa32);
        longint          sb = 64'(sb32);
        longint          d  = 64'(1) << (b % 32);
        longint          q;
        if (class_of(op) == 3'd7 || class_of(op) != sel) return 32'h0;
        case (op)
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return 32'(ua + ub);
            OP_SUB:  return 32'(ua + 64'h1_0000_0000 - ub);
            OP_SLL:  return 32'(ua * 64'(d));
            OP_SRL:  return 32'(ua / 64'(d));
            OP_SRA: begin
                q = (sa >= 0) ? sa / d : (sa - d + 1) / d;
                return 32'(q);
            end
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
`ifdef EX_PIPE_MUL_EN
            OP_MUL:  return 32'(ua * ub);
`endif
            default: return 32'h0;
        endcase
    endfunction

    vec_t vecs[12];
    logic [7:0] rand_ops[11];

    initial begin
        int          cyc;
        int          busy_n;
        int          seen_valid;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_wreg;
        logic        acc;
        int          n_rand_ops;

        vecs[0]  = '{OP_ADD,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd3,  1'b1, 32'h00000000, 1'b1};
        vecs[1]  = '{OP_OR,   SEL_LOGIC, 32'hF0F00000, 32'h0000F0F0, 5'd0,  1'b1, 32'hF0F0F0F0, 1'b0};
        vecs[2]  = '{8'hFF,   SEL_LOGIC, 32'h12345678, 32'h9ABCDEF0, 5'd7,  1'b1, 32'h00000000, 1'b1};
        vecs[3]  = '{OP_SUB,  SEL_ARITH, 32'h00000005, 32'h00000007, 5'd9,  1'b0, 32'hFFFFFFFE, 1'b0};
        vecs[4]  = '{OP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd4,  1'b1, 32'h00000001, 1'b1};
        vecs[5]  = '{OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd5,  1'b1, 32'h00000000, 1'b1};
        vecs[6]  = '{OP_SLL,  SEL_SHIFT, 32'h00000001, 32'h00000023, 5'd6,  1'b1, 32'h00000008, 1'b1};
        vecs[7]  = '{OP_SRL,  SEL_SHIFT, 32'h80000000, 32'h00000004, 5'd31, 1'b1, 32'h08000000, 1'b1};
        vecs[8]  = '{OP_XOR,  SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 5'd8,  1'b1, 32'hF0F0F0F0, 1'b1};
        vecs[9]  = '{OP_AND,  SEL_ARITH, 32'hFF00FF00, 32'h0FF00FF0, 5'd10, 1'b1, 32'h00000000, 1'b1};
        vecs[10] = '{OP_AND,  SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 5'd11, 1'b1, 32'h0F000F00, 1'b1};
        vecs[11] = '{OP_MUL,  SEL_ARITH, 32'h00000003, 32'h00000004, 5'd12, 1'b1, 32'h00000000, 1'b1};

        rand_ops = '{OP_OR, OP_AND, OP_XOR, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
                     OP_SLT, OP_SLTU, OP_MUL};
`ifdef EX_PIPE_MUL_EN
        n_rand_ops = 10;
`else
        n_rand_ops = 11;
`endif

        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        aluop_i = '0; alusel_i = '0; reg1_i = '0; reg2_i = '0; rd_i = '0; wreg_i = 1'b0;
        step(); step();
        check("reset valid_o", 64'(valid_o), 64'd0);
        check("reset wreg_o",  64'(wreg_o),  64'd0);
        check("reset rd_o",    64'(rd_o),    64'd0);
        check("reset wdata_o", 64'(wdata_o), 64'd0);
        check("reset busy_o",  64'(busy_o),  64'd0);
        rst = 1'b0;
        #1;
        check("reset ready_o", 64'(ready_o), 64'd1);

        // Directed vectors, back-to-back
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wreg);
            step();
            check($sformatf("vec%0d valid_o", i), 64'(valid_o), 64'd1);
            check($sformatf("vec%0d wdata_o", i), 64'(wdata_o), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d wreg_o", i),  64'(wreg_o),  64'(vecs[i].exp_wreg));
            check($sformatf("vec%0d rd_o", i),    64'(rd_o),    64'(vecs[i].rd));
        end
        valid_i = 1'b0;
        step();
        check("drain valid_o", 64'(valid_o), 64'd0);

        // SRA held under back-pressure while a new instruction waits
        drive(OP_SRA, SEL_SHIFT, 32'h80000000, 32'h00000004, 5'd2, 1'b1);
        ready_i = 1'b0;
        step();
        check("sra wdata_o", 64'(wdata_o), 64'hF8000000);
        drive(OP_ADD, SEL_ARITH, 32'h1, 32'h1, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d ready_o", i), 64'(ready_o), 64'd0);
            step();
            check($sformatf("hold%0d valid_o", i), 64'(valid_o), 64'd1);
            check($sformatf("hold%0d wdata_o", i), 64'(wdata_o), 64'hF8000000);
            check($sformatf("hold%0d rd_o", i),    64'(rd_o),    64'd2);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check("release valid_o", 64'(valid_o), 64'd0);

        // Random single-cycle traffic with random back-pressure
        exp_valid = 1'b0; exp_data = '0; exp_rd = '0; exp_wreg = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] op;
            logic [2:0] sel;
            op  = rand_ops[$urandom_range(0, n_rand_ops - 1)];
            sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : class_of(op);
            drive(op, sel, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            valid_i = 1'($urandom_range(0, 3) != 0);
            ready_i = 1'($urandom_range(0, 2) != 0);
            #1;
            exp_ready = !exp_valid || ready_i;
            check($sformatf("rand%0d ready_o", i), 64'(ready_o), 64'(exp_ready));
            acc = valid_i && exp_ready;
            if (acc) begin
                exp_valid = 1'b1;
                exp_data  = ref_alu(aluop_i, alusel_i, reg1_i, reg2_i);
                exp_rd    = rd_i;
                exp_wreg  = wreg_i && (rd_i != 5'd0);
            end else if (ready_i) begin
                exp_valid = 1'b0;
            end
            step();
            check($sformatf("rand%0d valid_o", i), 64'(valid_o), 64'(exp_valid));
            if (exp_valid) begin
                check($sformatf("rand%0d wdata_o", i), 64'(wdata_o), 64'(exp_data));
                check($sformatf("rand%0d rd_o", i),    64'(rd_o),    64'(exp_rd));
                check($sformatf("rand%0d wreg_o", i),  64'(wreg_o),  64'(exp_wreg));
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();

        // Multiply: latency and busy window, or unknown-op behaviour
        drive(OP_MUL, SEL_MUL, 32'h00012345, 32'h00000010, 5'd13, 1'b1);
        step();
        valid_i = 1'b0;
`ifdef EX_PIPE_MUL_EN
        cyc = 0; busy_n = 0;
        while (!valid_o && cyc < 100) begin
            if (busy_o) busy_n++;
            step();
            cyc++;
        end
        check("mul busy cycles", 64'(busy_n), 64'd32);
        check("mul latency",     64'(cyc),    64'd32);
        check("mul valid_o",     64'(valid_o), 64'd1);
        check("mul wdata_o",     64'(wdata_o), 64'h00123450);
        check("mul rd_o",        64'(rd_o),    64'd13);
        check("mul busy_o done", 64'(busy_o),  64'd0);
        step();

        // Flush mid-multiply
        drive(OP_MUL, SEL_MUL, 32'h00000007, 32'h00000009, 5'd14, 1'b1);
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("flush busy_o before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        #1;
        check("flush ready_o", 64'(ready_o), 64'd0);
        step();
        flush_i = 1'b0;
        #1;
        check("flush valid_o", 64'(valid_o), 64'd0);
        check("flush busy_o",  64'(busy_o),  64'd0);
        check("flush ready_o after", 64'(ready_o), 64'd1);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o) seen_valid++;
        end
        check("flush no result", 64'(seen_valid), 64'd0);

        // Reset mid-multiply
        drive(OP_MUL, SEL_MUL, 32'h00000007, 32'h00000009, 5'd15, 1'b1);
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst mul busy_o", 64'(busy_o), 64'd0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o) seen_valid++;
        end
        check("rst mul no result", 64'(seen_valid), 64'd0);
`else
        check("mul off valid_o", 64'(valid_o), 64'd1);
        check("mul off wdata_o", 64'(wdata_o), 64'd0);
        check("mul off rd_o",    64'(rd_o),    64'd13);
        check("mul off busy_o",  64'(busy_o),  64'd0);
        step();
`endif

        // Reset mid-stream overrides a valid instruction
        drive(OP_ADD, SEL_ARITH, 32'h00000010, 32'h00000020, 5'd17, 1'b1);
        step();
        check("pre-rst wdata_o", 64'(wdata_o), 64'h30);
        rst = 1'b1;
        flush_i = 1'b1;
        step();
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst wreg_o",  64'(wreg_o),  64'd0);
        check("rst rd_o",    64'(rd_o),    64'd0);
        check("rst wdata_o", 64'(wdata_o), 64'd0);
        check("rst busy_o",  64'(busy_o),  64'd0);
        rst = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        step();
        check("post-rst valid_o", 64'(valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits.
REQ-002 Parameter RADDR_W, default 5, destination register address width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  upstream presents an instruction.
REQ-006 ready_o  output  1  block accepts an instruction this cycle.
REQ-007 aluop_i  input  8  operation code: OR, AND, XOR, ADD, SUB, SLL, SRL, SRA, SLT, SLTU, MUL.
REQ-008 alusel_i  input  3  result class: LOGIC, SHIFT, ARITH, MUL.
REQ-009 reg1_i, reg2_i  input  XLEN each  source operands.
REQ-010 rd_i  input  RADDR_W  destination register; wreg_i  input  1  write-back request.
REQ-011 flush_i  input  1  discard in-flight and held instruction.
REQ-012 valid_o  output  1  result available; ready_i  input  1  downstream accepts the result.
REQ-013 rd_o  output  RADDR_W; wreg_o  output  1; wdata_o  output  XLEN  registered result.
REQ-014 busy_o  output  1  multi-cycle operation in progress.

Function
REQ-015 An instruction is accepted on a rising edge where valid_i and ready_o are both high.
REQ-016 ready_o SHALL equal (state==IDLE) and (valid_o==0 or ready_i==1), combinationally.
REQ-017 LOGIC/SHIFT/ARITH ops accepted at edge k SHALL present valid_o=1 and the result from edge k onward (1-cycle latency).
REQ-018 Shift amount SHALL be reg2_i[log2(XLEN)-1:0]; SRA sign-extends; SLT signed, SLTU unsigned, result 1 or 0.
REQ-019 ADD/SUB SHALL wrap modulo 2^XLEN.
REQ-020 Unknown aluop or alusel, or an aluop/alusel mismatch, SHALL produce wdata_o=0 with rd/wreg passed through.
REQ-021 wreg_o SHALL be forced 0 when rd_i==0.
REQ-022 States: IDLE, MUL. IDLE->MUL on accepting MUL; MUL->IDLE after XLEN iterations, or on flush_i.
REQ-023 MUL SHALL be an iterative shift-add producing the low XLEN bits of reg1_i*reg2_i; MUL accepted at edge k presents valid_o=1 from edge k+XLEN; busy_o=1 while in MUL.
REQ-024 With valid_o=1 and ready_i=0, rd_o/wreg_o/wdata_o/valid_o SHALL hold unchanged.
REQ-025 With valid_o=1, ready_i=1 and no new acceptance, valid_o SHALL clear on the next edge; with acceptance the same edge replaces the result (back-to-back throughput 1/cycle for single-cycle ops).
REQ-026 flush_i SHALL take priority on its edge: valid_o<=0, state<=IDLE, counter<=0, no acceptance that cycle (ready_o forced 0 while flush_i high).

Reset
REQ-027 On rst at a rising edge: state=IDLE, counter=0, valid_o=0, wreg_o=0, rd_o=0, wdata_o=0, busy_o=0; rst overrides flush_i and valid_i.
REQ-028 rst asserted mid-MUL SHALL abandon the operation with no result emitted.

Configuration
REQ-029 Macro EX_PIPE_MUL_EN: defined -> MUL state machine and multiplier compiled in per REQ-022/023.
REQ-030 Undefined -> no MUL state or multiplier; MUL treated as unknown op per REQ-020 with 1-cycle latency; busy_o tied 0.

Structure
REQ-031 aluop/alusel encodings, XLEN default and ZeroWord SHALL live in the shared defines package, extended from the existing OR/LOGIC entries.
REQ-032 Multiplier SHALL be a sub-module ex_mul_iter (start, operands, done, product), instantiated only under EX_PIPE_MUL_EN.

Verification
REQ-033 ADD 0xFFFFFFFF+0x00000001, rd=3 -> next edge valid_o=1, wdata_o=0x00000000, wreg_o=1.
REQ-034 SRA 0x80000000 by 4, ready_i=0 for 3 cycles -> wdata_o=0xF8000000 held stable 3 cycles, ready_o=0 meanwhile.
REQ-035 MUL 0x00012345*0x00000010 (MUL_EN) -> busy_o high 32 cycles, valid_o at edge k+32, wdata_o=0x00123450.
REQ-036 MUL accepted, flush_i at iteration 10 -> no valid_o, state IDLE, ready_o=1 next cycle.
REQ-037 OR 0xF0F00000|0x0000F0F0 with rd=0, wreg_i=1 -> wdata_o=0xF0F0F0F0, wreg_o=0.
REQ-038 Unknown aluop 0xFF, or MUL with macro undefined -> wdata_o=0 after 1 cycle; rst mid-stream -> all outputs 0 next edge.
